text_overlay_ctrl: RTL and testbench
====================================

Name: text_overlay_ctrl

Overview:
- Sequences the character message ROMs and the font ROM to draw one text message over the VGA pixel stream.
- Selects the message ROM for the current screen: none, start, pause or game over. The selection is latched only at frame boundaries.
- Walks the packed character address `char_xy` across a fixed text window and fetches font rows.
- Merges the glyph pixels onto `rgb_in` and delays all timing signals to match the pipeline.
- Sits between the VGA timing/background chain and the final RGB output.

Parameters:
- X_POS, 384, left pixel column of text window
- Y_POS, 300, top line of text window
- COLS, 31, characters per row (max 99)
- ROWS, 1, character rows (max 16)
- TEXT_RGB, 12'hFFF, glyph colour

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- screen_req  in  2  requested screen: 0 none, 1 start, 2 pause, 3 game over
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical line counter
- hsync_in  in  1  hsync
- vsync_in  in  1  vsync
- hblnk_in  in  1  horizontal blank
- vblnk_in  in  1  vertical blank
- rgb_in  in  12  background pixel
- rom_sel  out  2  selects which message ROM drives char_code (active screen)
- char_xy  out  12  {row[3:0], col_tens[3:0], col_units[3:0]}, BCD column
- char_code  in  7  ASCII from selected message ROM, registered, 1-cycle latency
- font_addr  out  11  {char_code, char_line[3:0]}, combinational
- font_data  in  8  font row, registered, 1-cycle latency, MSB = leftmost pixel
- hcount_out, vcount_out  out  11  inputs delayed 4 clk
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  inputs delayed 4 clk
- rgb_out  out  12  merged pixel, aligned with the delayed timing signals

Behaviour:
- Clock is `clk`. Reset is synchronous and active-low on `rst_n`; all state is updated on the rising edge of `clk`.
- Reset values: all delayed outputs 0; rgb_out 0; char_xy 12'h000; rom_sel 0; internal column/pixel counters 0; pipeline valid flags 0.
- Screen latch:
  - rom_sel (the active screen) loads screen_req only on the vblnk_in rising edge (vblnk_in=1 and previous sample 0).
  - A screen_req change mid-frame has no effect until the next vblnk rise.
- Window: in_win = (X_POS ≤ hcount_in < X_POS+8·COLS) and (Y_POS ≤ vcount_in < Y_POS+16·ROWS) and neither blank active.
- Row and line: dv = vcount_in − Y_POS; row = dv[7:4]; char_line = dv[3:0].
- Column sequencing (stage 0 → 1):
  - When hcount_in == X_POS: pixel counter pix := 0 and BCD column := 00.
  - Otherwise, while in_win, pix increments each clk. When pix == 7 it wraps to 0 and the column increments in BCD: units 9 → 0 carries into tens; column 09 is followed by 10.
  - char_xy is registered {row, col}. Outside the window char_xy holds its last value; its content is don't-care.
- Pipeline (pixel presented at cycle t):
  - t+1: char_xy valid.
  - t+2: char_code valid. font_addr = {char_code, line delayed 2}.
  - t+3: font_data valid.
  - t+4: rgb_out and all timing outputs registered.
  - pix, in_win and rgb_in are delayed 3 stages to line up with font_data.
- Merge at t+4:
  - rgb_out = TEXT_RGB if rom_sel ≠ 0 and in_win_d3 and font_data[7 − pix_d3] == 1.
  - Otherwise rgb_out = rgb_in_d3.
- rom_sel is sampled once for the merge decision. Because it only changes during vblank, no glyph is ever torn.
- Boundaries:
  - Leftmost window pixel (hcount == X_POS) uses column 00, pix 0.
  - Last window pixel uses column COLS−1, pix 7.
  - Pixel X_POS+8·COLS is outside the window: passthrough.
  - Screen 0: pure passthrough with 4-clk latency.
  - Reset mid-frame clears the pipeline and sets rom_sel to 0. Passthrough resumes immediately (rgb_out = 0 for the first 4 clk). Text returns after the next vblnk rise.
  - vblnk held high across reset: a rising edge is not detected until vblnk falls and rises again.

Test Plan:
- Reset: rst_n=0 for 3 clk with random inputs → all outputs 0. Release → hcount_out equals hcount_in from 4 clk earlier.
- Frame latch: screen_req=3 set mid-frame → rom_sel stays 0 until vblnk_in 0→1, then 3. Change to 1 mid-frame → rom_sel stays 3 until the next vblnk rise.
- Column walk: line vcount=300, hcount 384..631 → char_xy sequence 000 (×8), 001 (×8) … 009, 010 … 030. No hex codes 00A–00F appear.
- Glyph merge: ROM model returns "G", font_data=8'b1000_0001 → at hcount_out 384 and 391 rgb_out=FFF; at 385–390 rgb_out=rgb_in delayed.
- Screen none: screen_req=0 with font_data=8'hFF → rgb_out always equals rgb_in delayed 4 clk.
- Window edges: hcount 383 and 632 on line 300, and line 316 → passthrough; line 315 at hcount 384 → char_line=15.

Source files
------------

// File: rtl/text_overlay_ctrl.sv
// text_overlay_ctrl: draws one message, picked from four screens, over the
// VGA pixel stream. It walks a BCD character address across a fixed text
// window, fetches glyph rows from the font ROM, and merges the glyph pixels
// onto rgb_in. All timing outputs are delayed to line up with the merged pixel.
module text_overlay_ctrl #(
  parameter int          X_POS    = 384,
  parameter int          Y_POS    = 300,
  parameter int          COLS     = 31,
  parameter int          ROWS     = 1,
  parameter logic [11:0] TEXT_RGB = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  screen_req,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [1:0]  rom_sel,
  output logic [11:0] char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Window bounds in 12 bits so the right/bottom edge cannot overflow.
  localparam logic [11:0] X_LO    = 12'(X_POS);
  localparam logic [11:0] X_HI    = 12'(X_POS + 8 * COLS);
  localparam logic [11:0] Y_LO    = 12'(Y_POS);
  localparam logic [11:0] Y_HI    = 12'(Y_POS + 16 * ROWS);
  localparam logic [10:0] X_START = 11'(X_POS);
  localparam logic [7:0]  Y_BASE8 = 8'(Y_POS);

  // Timing bundle carried through the four-stage delay line.
  localparam int TW = 26;
  // Per-pixel data that must meet font_data three stages later.
  localparam int DW = 16;

  logic [11:0] h_ext;
  logic [11:0] v_ext;
  logic        in_win;
  logic [7:0]  dv;
  logic [3:0]  row;
  logic [3:0]  char_line;
  logic        at_start;

  logic [2:0]  pix_reg,   pix_cur,   pix_next;
  logic [3:0]  tens_reg,  tens_cur,  tens_next;
  logic [3:0]  units_reg, units_cur, units_next;
  logic [11:0] char_xy_reg;

  logic [1:0]  rom_sel_reg;
  logic        vblnk_prev_reg;

  logic [TW-1:0] tim_in;
  logic [TW-1:0] tim_pipe_reg [0:3];
  logic [DW-1:0] dat_in;
  logic [DW-1:0] dat_pipe_reg [0:2];
  logic [3:0]    line_pipe_reg [0:1];

  logic          win_d3;
  logic [2:0]    pix_d3;
  logic [11:0]   rgb_d3;
  logic [11:0]   rgb_out_reg;

  assign h_ext     = {1'b0, hcount_in};
  assign v_ext     = {1'b0, vcount_in};
  assign at_start  = (hcount_in == X_START);
  // Only the low 8 bits of the line offset are needed (16 rows x 16 lines).
  assign dv        = vcount_in[7:0] - Y_BASE8;
  assign row       = dv[7:4];
  assign char_line = dv[3:0];

  // Stage-0 window decode; blanking always forces passthrough.
  always_comb begin
    in_win = (h_ext >= X_LO) && (h_ext < X_HI) &&
             (v_ext >= Y_LO) && (v_ext < Y_HI) &&
             !hblnk_in && !vblnk_in;
  end

  // Column/pixel sequencing: the window's first pixel restarts at column 00,
  // then each 8 in-window pixels advance the column in BCD.
  always_comb begin
    pix_cur   = pix_reg;
    tens_cur  = tens_reg;
    units_cur = units_reg;
    if (at_start) begin
      pix_cur   = 3'd0;
      tens_cur  = 4'd0;
      units_cur = 4'd0;
    end
    pix_next   = pix_cur;
    tens_next  = tens_cur;
    units_next = units_cur;
    if (in_win) begin
      if (pix_cur == 3'd7) begin
        pix_next = 3'd0;
        if (units_cur == 4'd9) begin
          units_next = 4'd0;
          tens_next  = tens_cur + 4'd1;
        end else begin
          units_next = units_cur + 4'd1;
        end
      end else begin
        pix_next = pix_cur + 3'd1;
      end
    end
  end

  // Column counters and the registered character address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_reg     <= 3'd0;
      tens_reg    <= 4'd0;
      units_reg   <= 4'd0;
      char_xy_reg <= 12'h000;
    end else begin
      pix_reg   <= pix_next;
      tens_reg  <= tens_next;
      units_reg <= units_next;
      if (in_win) begin
        char_xy_reg <= {row, tens_cur, units_cur};
      end
    end
  end

  // Screen latch: only a vblank rising edge may change the active screen.
  // The edge detector powers up "high" so a vblank held through reset is
  // not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_sel_reg    <= 2'd0;
      vblnk_prev_reg <= 1'b1;
    end else begin
      vblnk_prev_reg <= vblnk_in;
      if (vblnk_in && !vblnk_prev_reg) begin
        rom_sel_reg <= screen_req;
      end
    end
  end

  assign tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
  assign dat_in = {in_win, pix_cur, rgb_in};

  genvar gi;

  // Four-stage delay of the raw timing signals.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tim
      if (gi == 0) begin : g_head
        // First timing stage captures the live inputs.
        always_ff @(posedge clk) begin
          if (!rst_n) tim_pipe_reg[gi] <= '0;
          else        tim_pipe_reg[gi] <= tim_in;
        end
      end else begin : g_tail
        // Later timing stages shift the previous stage.
        always_ff @(posedge clk) begin
          if (!rst_n) tim_pipe_reg[gi] <= '0;
          else        tim_pipe_reg[gi] <= tim_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  // Three-stage delay of window flag, pixel index and background colour.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dat
      if (gi == 0) begin : g_head
        // First data stage captures the stage-0 decode.
        always_ff @(posedge clk) begin
          if (!rst_n) dat_pipe_reg[gi] <= '0;
          else        dat_pipe_reg[gi] <= dat_in;
        end
      end else begin : g_tail
        // Later data stages shift the previous stage.
        always_ff @(posedge clk) begin
          if (!rst_n) dat_pipe_reg[gi] <= '0;
          else        dat_pipe_reg[gi] <= dat_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  // Two-stage delay of the glyph line so it meets char_code.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      if (gi == 0) begin : g_head
        // First line stage captures the current glyph line.
        always_ff @(posedge clk) begin
          if (!rst_n) line_pipe_reg[gi] <= 4'd0;
          else        line_pipe_reg[gi] <= char_line;
        end
      end else begin : g_tail
        // Second line stage aligns with the message ROM output.
        always_ff @(posedge clk) begin
          if (!rst_n) line_pipe_reg[gi] <= 4'd0;
          else        line_pipe_reg[gi] <= line_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign {win_d3, pix_d3, rgb_d3} = dat_pipe_reg[2];

  // Merge: glyph colour where the font bit is set inside the window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_out_reg <= 12'h000;
    end else if ((rom_sel_reg != 2'd0) && win_d3 && font_data[3'd7 - pix_d3]) begin
      rgb_out_reg <= TEXT_RGB;
    end else begin
      rgb_out_reg <= rgb_d3;
    end
  end

  assign font_addr = {char_code, line_pipe_reg[1]};
  assign char_xy   = char_xy_reg;
  assign rom_sel   = rom_sel_reg;
  assign rgb_out   = rgb_out_reg;
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_pipe_reg[3];

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// tb_text_overlay_ctrl: directed vectors for text_overlay_ctrl with simple
// registered message/font ROM models.
module tb_text_overlay_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  screen_req;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [1:0]  rom_sel;
  logic [11:0] char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [7:0]  font_pat;

  always #5 clk = ~clk;

  text_overlay_ctrl dut (
    .clk(clk), .rst_n(rst_n), .screen_req(screen_req),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .rom_sel(rom_sel), .char_xy(char_xy), .char_code(char_code),
    .font_addr(font_addr), .font_data(font_data),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  // Message ROM returns "G" for any active screen; font ROM returns font_pat.
  always @(posedge clk) begin
    char_code <= (rom_sel != 2'd0) ? 7'h47 : 7'h20;
    font_data <= font_pat;
  end

  int n_vec = 0;
  int n_bad = 0;
  int ecnt  = 0;
  logic [1:0] cur_scr;

  logic [10:0] hist_h [8];
  logic [11:0] hist_rgb [8];
  logic        hist_hs [8];

  typedef struct {
    logic [1:0]  scr;
    logic [10:0] v;
    logic [10:0] h;
    logic [7:0]  fpat;
    logic [11:0] rgb;
    logic [11:0] exp_rgb;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Record the inputs presented this cycle, then advance one clock.
  task automatic tick();
    hist_h[ecnt & 7]   = hcount_in;
    hist_rgb[ecnt & 7] = rgb_in;
    hist_hs[ecnt & 7]  = hsync_in;
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  function automatic int b3();
    return (ecnt - 4) & 7;
  endfunction

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = rgb;
    hblnk_in  = 1'b0;
    vblnk_in  = 1'b0;
    tick();
  endtask

  // Pulse vblank to latch a new screen.
  task automatic set_screen(input logic [1:0] s);
    screen_req = s;
    hcount_in = 11'd0; vcount_in = 11'd0; rgb_in = 12'h000;
    vblnk_in = 1'b0; tick();
    vblnk_in = 1'b1; tick();
    vblnk_in = 1'b0; tick();
    chk("screen_latch", 32'(rom_sel), 32'(s));
    cur_scr = s;
  endtask

  initial begin
    vecs[0]  = '{2'd3, 11'd300, 11'd384, 8'h81, 12'h0AB, 12'hFFF};
    vecs[1]  = '{2'd3, 11'd300, 11'd385, 8'h81, 12'h0AB, 12'h0AB};
    vecs[2]  = '{2'd3, 11'd300, 11'd390, 8'h81, 12'h0AB, 12'h0AB};
    vecs[3]  = '{2'd3, 11'd300, 11'd391, 8'h81, 12'h0AB, 12'hFFF};
    vecs[4]  = '{2'd3, 11'd300, 11'd383, 8'hFF, 12'h0C1, 12'h0C1};
    vecs[5]  = '{2'd3, 11'd300, 11'd631, 8'h01, 12'h0D2, 12'hFFF};
    vecs[6]  = '{2'd3, 11'd300, 11'd631, 8'hFE, 12'h0D2, 12'h0D2};
    vecs[7]  = '{2'd3, 11'd300, 11'd632, 8'hFF, 12'h0E3, 12'h0E3};
    vecs[8]  = '{2'd3, 11'd316, 11'd384, 8'hFF, 12'h0F4, 12'h0F4};
    vecs[9]  = '{2'd3, 11'd299, 11'd384, 8'hFF, 12'h105, 12'h105};
    vecs[10] = '{2'd3, 11'd315, 11'd384, 8'h80, 12'h216, 12'hFFF};
    vecs[11] = '{2'd3, 11'd300, 11'd396, 8'h08, 12'h327, 12'hFFF};
    vecs[12] = '{2'd3, 11'd300, 11'd396, 8'h10, 12'h327, 12'h327};
    vecs[13] = '{2'd1, 11'd300, 11'd392, 8'h80, 12'h438, 12'hFFF};
    vecs[14] = '{2'd2, 11'd300, 11'd399, 8'h01, 12'h549, 12'hFFF};
    vecs[15] = '{2'd0, 11'd300, 11'd384, 8'hFF, 12'h65A, 12'h65A};

    font_pat = 8'h00;
    screen_req = 2'd0;
    cur_scr = 2'd0;
    hsync_in = 1'b0; vsync_in = 1'b0;

    // Reset with random inputs: every output must be zero.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hcount_in = 11'($urandom); vcount_in = 11'($urandom);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      hblnk_in = 1'($urandom); vblnk_in = 1'($urandom);
      rgb_in = 12'($urandom); screen_req = 2'($urandom);
      tick();
    end
    chk("rst_rgb_out", 32'(rgb_out), 32'h0);
    chk("rst_hcount_out", 32'(hcount_out), 32'h0);
    chk("rst_vcount_out", 32'(vcount_out), 32'h0);
    chk("rst_flags", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    chk("rst_char_xy", 32'(char_xy), 32'h0);
    chk("rst_rom_sel", 32'(rom_sel), 32'h0);

    // Release: pipeline stays zero for 3 edges, then shows inputs 4 clk old.
    rst_n = 1'b1;
    screen_req = 2'd0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hsync_in = 1'($urandom);
      drive(11'($urandom_range(0, 300)), 11'd0, 12'($urandom));
      if (i < 3) begin
        chk("post_rst_hcount_zero", 32'(hcount_out), 32'h0);
        chk("post_rst_rgb_zero", 32'(rgb_out), 32'h0);
      end else begin
        chk("post_rst_hcount_delay", 32'(hcount_out), 32'(hist_h[b3()]));
        chk("post_rst_rgb_delay", 32'(rgb_out), 32'(hist_rgb[b3()]));
      end
    end
    hsync_in = 1'b0;

    // Frame latch: mid-frame requests wait for a vblank rising edge.
    screen_req = 2'd3;
    for (int i = 0; i < 5; i++) drive(11'd10, 11'd100, 12'h000);
    chk("latch_hold_0", 32'(rom_sel), 32'h0);
    vblnk_in = 1'b1; tick();
    chk("latch_rise_3", 32'(rom_sel), 32'h3);
    screen_req = 2'd1;
    tick();
    chk("latch_high_still_3", 32'(rom_sel), 32'h3);
    for (int i = 0; i < 3; i++) drive(11'd20, 11'd100, 12'h000);
    chk("latch_mid_still_3", 32'(rom_sel), 32'h3);
    vblnk_in = 1'b1; tick();
    chk("latch_rise_1", 32'(rom_sel), 32'h1);
    vblnk_in = 1'b0; tick();

    // Vblank held high through reset is not a rising edge.
    screen_req = 2'd2;
    vblnk_in = 1'b1;
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("vblnk_held_no_latch", 32'(rom_sel), 32'h0);
    vblnk_in = 1'b0; tick();
    vblnk_in = 1'b1; tick();
    chk("vblnk_reedge_latch", 32'(rom_sel), 32'h2);
    vblnk_in = 1'b0; tick();
    cur_scr = 2'd2;

    // Column walk across line 300: BCD columns 00..30, 8 pixels each.
    set_screen(2'd3);
    for (int h = 382; h <= 633; h++) begin
      drive(11'(h), 11'd300, 12'h000);
      if (h >= 384 && h <= 631) begin
        int c;
        c = (h - 384) / 8;
        chk("col_walk_char_xy", 32'(char_xy), {20'h0, 4'h0, 4'(c / 10), 4'(c % 10)});
      end
    end

    // Glyph line 15 at the bottom line of the window.
    drive(11'd383, 11'd315, 12'h000);
    drive(11'd384, 11'd315, 12'h000);
    chk("line315_char_xy", 32'(char_xy), 32'h000);
    drive(11'd385, 11'd315, 12'h000);
    chk("line315_font_addr", 32'(font_addr), 32'({7'h47, 4'hF}));

    // Table-driven merge vectors: walk the line from 382 to the target pixel.
    for (int i = 0; i < NV; i++) begin
      if (cur_scr != vecs[i].scr) set_screen(vecs[i].scr);
      font_pat = vecs[i].fpat;
      for (int h = 382; h <= int'(vecs[i].h) + 3; h++) begin
        drive(11'(h), vecs[i].v, (h == int'(vecs[i].h)) ? vecs[i].rgb : 12'h555);
      end
      chk($sformatf("vec%0d_rgb_out", i), 32'(rgb_out), 32'(vecs[i].exp_rgb));
      chk($sformatf("vec%0d_hcount_out", i), 32'(hcount_out), 32'(vecs[i].h));
    end

    // Screen none: pure passthrough even with an all-ones font row.
    set_screen(2'd0);
    font_pat = 8'hFF;
    for (int h = 380; h <= 640; h++) begin
      hsync_in = 1'($urandom);
      drive(11'(h), 11'd300, 12'($urandom));
      if (h >= 383) begin
        chk("none_rgb_passthrough", 32'(rgb_out), 32'(hist_rgb[b3()]));
        chk("none_hsync_delay", 32'(hsync_out), 32'(hist_hs[b3()]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
